// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit control slice.
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } sched_state_t;

    localparam int DATA_W       = 8;
    localparam int BUSY_TIMEOUT = 3;

endpackage

// File: rtl/uart_baud_gen.sv
// 16x oversampling tick generator for the UART core.
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             baud_en,
    input  logic [DIV_W-1:0] baud_div,
    output logic             baud16_en
);

    logic [DIV_W-1:0] cnt;
    logic             wrap;

    // >= rather than == so a divisor lowered below the running count wraps at once
    assign wrap = (cnt >= baud_div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            baud16_en <= 1'b0;
        end else if (!baud_en) begin
            cnt       <= '0;
            baud16_en <= 1'b0;
        end else begin
            baud16_en <= wrap;
            cnt       <= wrap ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NREQ byte requesters.
//   state     | meaning
//   IDLE      | arbitrate; grant when a req is pending and the UART is free
//   LOAD      | one cycle: pulse uart_tx_start and ack[grant]
//   WAIT_BUSY | wait for the UART to take the byte (watchdog armed)
//   WAIT_DONE | wait for the UART to finish the frame
module uart_tx_scheduler
    import uart_ctrl_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int DIV_W = 16,
    localparam int GW    = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [DATA_W*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]          ack,
    input  logic [DIV_W-1:0]         baud_div,
    input  logic                     baud_en,
    input  logic                     uart_tx_busy,
    output logic [DATA_W-1:0]        uart_tx_data,
    output logic                     uart_tx_start,
    output logic                     baud16_en,
    output logic [GW-1:0]            grant_id,
    output logic                     sched_busy
);

    sched_state_t  state;
    logic [GW-1:0] last_grant;
    logic [GW-1:0] win;
    logic          win_vld;
    logic [1:0]    wd_cnt;

    always_comb begin
        int idx;
        idx     = 0;
        win     = last_grant;
        win_vld = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(last_grant) + i) % NREQ;
            if (!win_vld && req[idx]) begin
                win     = GW'(idx);
                win_vld = 1'b1;
            end
        end
    end

    // The LOAD cycle counts as the first cycle of the busy budget
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_grant    <= GW'(NREQ - 1);
            grant_id      <= '0;
            uart_tx_data  <= '0;
            uart_tx_start <= 1'b0;
            ack           <= '0;
            wd_cnt        <= '0;
        end else begin
            uart_tx_start <= 1'b0;
            ack           <= '0;
            case (state)
                IDLE: begin
                    if (win_vld && !uart_tx_busy) begin
                        uart_tx_data  <= req_data[int'(win)*DATA_W +: DATA_W];
                        grant_id      <= win;
                        last_grant    <= win;
                        uart_tx_start <= 1'b1;
                        ack           <= NREQ'(1) << win;
                        wd_cnt        <= 2'(BUSY_TIMEOUT);
                        state         <= LOAD;
                    end
                end
                LOAD: begin
                    wd_cnt <= wd_cnt - 1'b1;
                    state  <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (uart_tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (wd_cnt == 2'd1) begin
                        state <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt - 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!uart_tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sched_busy = (state != IDLE);

    uart_baud_gen #(
        .DIV_W(DIV_W)
    ) u_baud_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .baud_en  (baud_en),
        .baud_div (baud_div),
        .baud16_en(baud16_en)
    );

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin transmit scheduler that shares the single UART transmitter among NREQ byte requesters and generates the UART's 16x oversampling tick. It sits between the client logic and the `uart` core, driving `tx_data`, `tx_start` and `baud16_en` and observing `tx_busy`. At most one byte is in flight at a time, and no requester can starve another.

## Interface
- NREQ, 4, number of requesters (2..8)
- DIV_W, 16, width of baud divisor

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- req  in  NREQ  per-requester transmit request, level, held until ack
- req_data  in  8*NREQ  byte for requester i at bits [8i+7:8i], stable while req[i]=1
- ack  out  NREQ  one-cycle pulse: byte of requester i accepted by UART
- baud_div  in  DIV_W  tick period minus one, in clk cycles
- baud_en  in  1  tick generator enable
- uart_tx_busy  in  1  from uart tx_busy
- uart_tx_data  out  8  to uart tx_data
- uart_tx_start  out  1  to uart tx_start, one-cycle pulse
- baud16_en  out  1  to uart baud16_en, one-cycle pulse
- grant_id  out  clog2(NREQ)  index of current/last granted requester
- sched_busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If any req bit is set and uart_tx_busy=0, pick the winner g: the first set bit searching from (last_grant+1) mod NREQ upward, wrapping.
  - Register uart_tx_data <= req_data[g], grant_id <= g, last_grant <= g, then go to LOAD.
- LOAD (exactly 1 cycle): assert uart_tx_start=1 and ack[g]=1, then go to WAIT_BUSY.
- WAIT_BUSY: wait for uart_tx_busy=1, then go to WAIT_DONE.
  - Watchdog: if busy is not seen within 3 cycles, return to IDLE without re-acking. The byte is lost.
- WAIT_DONE: wait for uart_tx_busy=0, then go to IDLE.
- uart_tx_data holds its value from LOAD until the next LOAD.
- Requesters:
  - A requester sees ack once per byte.
  - A requester may drop req after ack, or keep it high to queue another byte.
  - A req withdrawn before grant is simply not selected.
- Baud generator:
  - Counter cnt counts 0..baud_div. It pulses baud16_en when cnt==baud_div and baud_en=1, then cnt returns to 0.
  - baud_div=0 gives a tick every cycle.
  - baud_en=0 holds cnt at 0 and gives no ticks.
  - If baud_div is lowered below cnt, the next cycle ticks and wraps.

## Timing
- Reset values: ack=0, uart_tx_start=0, uart_tx_data=8'h00, grant_id=0, sched_busy=0, baud16_en=0, state=IDLE, last_grant=NREQ-1 (so requester 0 wins first), cnt=0.
- Request to start latency:
  - req seen in IDLE at cycle t.
  - LOAD at t+1: uart_tx_start=1 and ack=1, same cycle.
  - uart_tx_busy rises at t+2.
- After uart_tx_busy falls at cycle d, the FSM is in IDLE at d+1 and the next LOAD is at d+2. The minimum inter-frame gap is 2 cycles.
- Simultaneous requests in one cycle: exactly one grant per arbitration, in round-robin order.
- req[g] dropping during WAIT_* has no effect on the frame in flight.
- A new req arriving during WAIT_* waits for IDLE.
- Reset asserted mid-frame:
  - All outputs return to reset values asynchronously.
  - No ack is issued for an unfinished frame.
  - The UART core is reset by the same rst.

## Structure
- Package uart_ctrl_pkg holds:
  - the FSM state enum (sched_state_t: IDLE, LOAD, WAIT_BUSY, WAIT_DONE);
  - DATA_W=8;
  - BUSY_TIMEOUT=3.
- Sub-module uart_baud_gen (parameter DIV_W; ports clk, rst_n, baud_en, baud_div, baud16_en) contains the divider counter.
- The arbiter and FSM stay in the top.

## Test plan
- Single request: req=4'b0001, req_data[7:0]=8'hA5, baud_div=0, UART model raises busy 1 cycle after start for 160 cycles -> uart_tx_data=A5, one ack[0] pulse at LOAD, uart_tx_start high exactly 1 cycle, sched_busy high until 1 cycle after busy falls.
- Contention: req=4'b1111 held continuously, data bytes 10,11,12,13 -> grant order 0,1,2,3,0; each ack exactly once per frame; 2-cycle gap between frames.
- Round-robin fairness: req[0] always high and req[2] toggled on -> after a frame for 0, the next grant goes to 2, never 0 twice in a row.
- Baud generator:
  - baud_div=3, baud_en=1 -> baud16_en pulses every 4 cycles.
  - Switch baud_div to 1 when cnt=3 -> tick on the next cycle, then every 2 cycles.
  - baud_en=0 -> no ticks.
- Busy watchdog: UART model never raises busy -> FSM returns to IDLE 3 cycles after LOAD, no second ack, next requester served.
- Reset mid-frame: rst_n low during WAIT_DONE -> all outputs at reset values immediately; after release, req=4'b0100 is granted first.
